// File: rtl/icache_ctrl.sv
// icache_ctrl: direct-mapped icache controller (tag/valid arrays, hit/miss, line fill).
// Latency: hits respond combinationally in the request cycle; misses respond in the pmem_resp cycle.
// Backpressure: the CPU holds mem_read until mem_resp; the fill holds pmem_read until pmem_resp.
// Ports: mem_* = fetch side, pmem_* = line-fill side, arr_* = data-array control,
//        flush = invalidate all lines, hit_count/miss_count = saturating statistics.
module icache_ctrl #(
  parameter int ADDR_W   = 32,
  parameter int NUM_SETS = 8,
  parameter int LINE_W   = 256,
  parameter int CNT_W    = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        mem_read,
  input  logic [ADDR_W-1:0]           mem_address,
  output logic [31:0]                 mem_rdata,
  output logic                        mem_resp,
  input  logic                        flush,
  output logic                        pmem_read,
  output logic [ADDR_W-1:0]           pmem_address,
  input  logic [LINE_W-1:0]           pmem_rdata,
  input  logic                        pmem_resp,
  output logic [31:0]                 arr_load,
  output logic [$clog2(NUM_SETS)-1:0] arr_rindex,
  output logic [$clog2(NUM_SETS)-1:0] arr_windex,
  output logic [LINE_W-1:0]           arr_datain,
  input  logic [LINE_W-1:0]           arr_dataout,
  output logic [CNT_W-1:0]            hit_count,
  output logic [CNT_W-1:0]            miss_count
);

  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam int WSEL_W = $clog2(LINE_W / 32);
  localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;

  typedef enum logic {IDLE, FILL} state_t;

  state_t               state, state_nxt;
  logic [NUM_SETS-1:0]  valid, valid_nxt;
  logic [TAG_W-1:0]     tags [NUM_SETS];
  logic [TAG_W-1:0]     fill_tag;
  logic [IDX_W-1:0]     fill_idx;
  logic [WSEL_W-1:0]    fill_wsel;

  logic [TAG_W-1:0]     req_tag;
  logic [IDX_W-1:0]     req_idx;
  logic [WSEL_W-1:0]    req_wsel;
  logic                 hit;
  logic                 hit_inc;
  logic                 miss_start;
  logic                 fill_done;

  assign req_tag  = mem_address[ADDR_W-1 -: TAG_W];
  assign req_idx  = mem_address[OFF_W +: IDX_W];
  assign req_wsel = mem_address[2 +: WSEL_W];

  // A flush in the request cycle forces a miss so stale lines are never returned.
  assign hit = valid[req_idx] && (tags[req_idx] == req_tag) && !flush;

  assign arr_rindex   = req_idx;
  assign arr_windex   = fill_idx;
  assign arr_datain   = pmem_rdata;
  assign pmem_address = {fill_tag, fill_idx, {OFF_W{1'b0}}};

  always_comb begin
    state_nxt  = state;
    mem_resp   = 1'b0;
    mem_rdata  = '0;
    pmem_read  = 1'b0;
    arr_load   = '0;
    hit_inc    = 1'b0;
    miss_start = 1'b0;
    fill_done  = 1'b0;
    case (state)
      IDLE: begin
        if (mem_read) begin
          if (hit) begin
            mem_resp  = 1'b1;
            mem_rdata = arr_dataout[32*req_wsel +: 32];
            hit_inc   = 1'b1;
          end else begin
            miss_start = 1'b1;
            state_nxt  = FILL;
          end
        end
      end
      FILL: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          fill_done = 1'b1;
          arr_load  = '1;
          state_nxt = IDLE;
          // Fill data is forwarded straight to the CPU; the line is installed
          // regardless, but a withdrawn request gets no response.
          if (mem_read) begin
            mem_resp  = 1'b1;
            mem_rdata = pmem_rdata[32*fill_wsel +: 32];
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The fill write wins over a simultaneous flush for its own set.
  always_comb begin
    valid_nxt = valid;
    if (flush) valid_nxt = '0;
    if (fill_done) valid_nxt[fill_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      valid      <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      state <= state_nxt;
      valid <= valid_nxt;
      if (hit_inc && (hit_count != '1))
        hit_count <= hit_count + {{(CNT_W-1){1'b0}}, 1'b1};
      if (miss_start && (miss_count != '1))
        miss_count <= miss_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Tags and fill context need no reset: valid bits and state qualify them.
  always_ff @(posedge clk) begin
    if (miss_start) begin
      fill_tag  <= req_tag;
      fill_idx  <= req_idx;
      fill_wsel <= req_wsel;
    end
    if (fill_done)
      tags[fill_idx] <= fill_tag;
  end

endmodule
